// File: rtl/tdm_demux8.sv
// ---------------------------------------------------------------------------
// tdm_demux8
//   Receive end of an N:1 time-division link. The transmitter scans its slot
//   select 0..CHANNELS-1, one slot per enabled clock. This block aligns on
//   frame sync, collects each serial slot into a shadow register, and
//   publishes the complete frame on y with a one-cycle frame_valid strobe.
//   Loss or misplacement of frame sync is flagged with a one-cycle sync_err.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   en           in   slot advance enable (0 = stall: no sample, no count)
//   fsync        in   frame sync, high together with slot 0 data
//   din          in   serial slot data, WIDTH bits
//   y            out  frame outputs, y[i*WIDTH +: WIDTH] = slot i
//   frame_valid  out  1-cycle pulse: y holds a newly completed frame
//   sync_err     out  1-cycle pulse: sync missing or misplaced
//   locked       out  high while aligned (RUN)
//   slot         out  slot index sampled at the next enabled edge
// ---------------------------------------------------------------------------
module tdm_demux8 #(
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int WIDTH    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        fsync,
    input  logic [WIDTH-1:0]            din,
    output logic [CHANNELS*WIDTH-1:0]   y,
    output logic                        frame_valid,
    output logic                        sync_err,
    output logic                        locked,
    output logic [SEL_W-1:0]            slot
);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(CHANNELS - 1);

    state_t                           r_state;
    logic [SEL_W-1:0]                 r_slot;
    logic [(CHANNELS-1)*WIDTH-1:0]    r_shadow;
    logic [CHANNELS*WIDTH-1:0]        r_y;
    logic                             r_frame_valid;
    logic                             r_sync_err;
    logic                             r_locked;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= HUNT;
            r_slot        <= '0;
            r_shadow      <= '0;
            r_y           <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            // Strobes last exactly one cycle; stalled cycles drive them low.
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            if (en) begin
                case (r_state)
                    HUNT: begin
                        if (fsync) begin
                            r_shadow[WIDTH-1:0] <= din;
                            r_slot              <= SEL_W'(1);
                            r_state             <= RUN;
                            r_locked            <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (r_slot == '0) begin
                            if (fsync) begin
                                r_shadow[WIDTH-1:0] <= din;
                                r_slot              <= SEL_W'(1);
                            end else begin
                                // Sync expected here but absent: drop to HUNT.
                                r_sync_err <= 1'b1;
                                r_state    <= HUNT;
                                r_locked   <= 1'b0;
                            end
                        end else if (fsync) begin
                            // Misplaced sync: discard partial frame, realign
                            // treating this edge as slot 0.
                            r_sync_err          <= 1'b1;
                            r_shadow[WIDTH-1:0] <= din;
                            r_slot              <= SEL_W'(1);
                        end else if (r_slot == LAST_SLOT) begin
                            r_y           <= {din, r_shadow};
                            r_frame_valid <= 1'b1;
                            r_slot        <= '0;
                        end else begin
                            for (int unsigned i = 1; i < CHANNELS - 1; i++) begin
                                if (r_slot == SEL_W'(i))
                                    r_shadow[i*WIDTH +: WIDTH] <= din;
                            end
                            r_slot <= r_slot + SEL_W'(1);
                        end
                    end
                    default: begin
                        r_state  <= HUNT;
                        r_slot   <= '0;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign y           = r_y;
    assign frame_valid = r_frame_valid;
    assign sync_err    = r_sync_err;
    assign locked      = r_locked;
    assign slot        = r_slot;

endmodule
